// File: rtl/lcd_nibble_sequencer_pkg.sv
// Shared types and constants for the 4-bit HD44780-style LCD write sequencer.
package lcd_nibble_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_STEP,
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_PULSE_LO,
        ST_EXEC
    } state_e;

    typedef enum logic [1:0] {
        WAIT_INIT_LONG,
        WAIT_EXEC_X3,
        WAIT_EXEC
    } wait_sel_e;

    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;

    localparam int INIT_LEN   = 8;
    localparam int INIT_IDX_W = 3;

    // Clear and return-home need the long execution wait on the controller.
    function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-on init table: index to {nibble_only, value, wait_sel}.
module lcd_init_rom
    import lcd_nibble_sequencer_pkg::*;
(
    input  logic [INIT_IDX_W-1:0] idx_i,
    output logic                  nibble_only_o,
    output logic [7:0]            value_o,
    output wait_sel_e             wait_sel_o
);

    // Nibble-only steps keep their nibble in value[7:4] so both step kinds share the high-nibble path.
    always_comb begin
        nibble_only_o = 1'b0;
        value_o       = 8'h00;
        wait_sel_o    = WAIT_EXEC;
        case (idx_i)
            3'd0: begin
                nibble_only_o = 1'b1;
                value_o       = 8'h30;
                wait_sel_o    = WAIT_INIT_LONG;
            end
            3'd1: begin
                nibble_only_o = 1'b1;
                value_o       = 8'h30;
                wait_sel_o    = WAIT_EXEC_X3;
            end
            3'd2: begin
                nibble_only_o = 1'b1;
                value_o       = 8'h30;
            end
            3'd3: begin
                nibble_only_o = 1'b1;
                value_o       = 8'h20;
            end
            3'd4:    value_o = FUNC_SET;
            3'd5:    value_o = ENTRY;
            3'd6:    value_o = DISP_ON;
            default: value_o = CLEAR;
        endcase
    end

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// Write-only 4-bit LCD sequencer: power-on init, then byte writes as two e-pulsed nibbles.
module lcd_nibble_sequencer
    import lcd_nibble_sequencer_pkg::*;
#(
    parameter int PWRUP_CYC     = 750000,
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int GAP_CYC       = 50,
    parameter int EXEC_CYC      = 2000,
    parameter int CLEAR_CYC     = 82000,
    parameter int INIT_LONG_CYC = 205000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_4,
    output logic       lcd_5,
    output logic       lcd_6,
    output logic       lcd_7
);

    localparam int MAX_A   = (PWRUP_CYC > INIT_LONG_CYC) ? PWRUP_CYC : INIT_LONG_CYC;
    localparam int MAX_B   = (CLEAR_CYC > EXEC_CYC * 3) ? CLEAR_CYC : EXEC_CYC * 3;
    localparam int MAX_C   = (GAP_CYC > PULSE_CYC) ? GAP_CYC : PULSE_CYC;
    localparam int MAX_D   = (MAX_C > SETUP_CYC) ? MAX_C : SETUP_CYC;
    localparam int MAX_E   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_E > MAX_D) ? MAX_E : MAX_D;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [INIT_IDX_W-1:0] idx_q;
    logic                  init_done_q;
    logic                  nib_only_q;
    logic                  rs_q;
    logic [7:0]            data_q;
    logic                  lcd_e_q;
    logic                  lcd_rs_q;
    logic [3:0]            nib_q;

    logic                  rom_nib_only;
    logic [7:0]            rom_value;
    wait_sel_e             rom_wait;
    logic [CNT_W-1:0]      exec_load_d;
    logic                  cnt_zero;

    lcd_init_rom u_init_rom (
        .idx_i         (idx_q),
        .nibble_only_o (rom_nib_only),
        .value_o       (rom_value),
        .wait_sel_o    (rom_wait)
    );

    assign cnt_zero = (cnt_q == '0);

    // The ROM index is held through the whole step, so a nibble-only wait can be read at EXEC entry.
    always_comb begin
        exec_load_d = CNT_W'(EXEC_CYC - 1);
        if (nib_only_q) begin
            case (rom_wait)
                WAIT_INIT_LONG: exec_load_d = CNT_W'(INIT_LONG_CYC - 1);
                WAIT_EXEC_X3:   exec_load_d = CNT_W'(EXEC_CYC * 3 - 1);
                default:        exec_load_d = CNT_W'(EXEC_CYC - 1);
            endcase
        end else if (is_clear_cmd(rs_q, data_q)) begin
            exec_load_d = CNT_W'(CLEAR_CYC - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= CNT_W'(PWRUP_CYC - 1);
            idx_q       <= '0;
            init_done_q <= 1'b0;
            nib_only_q  <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            nib_q       <= 4'h0;
        end else begin
            if (!cnt_zero) begin
                cnt_q <= cnt_q - 1'b1;
            end
            case (state_q)
                ST_PWRUP: begin
                    if (cnt_zero) begin
                        state_q <= ST_INIT_STEP;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_INIT_STEP: begin
                    nib_only_q <= rom_nib_only;
                    rs_q       <= 1'b0;
                    data_q     <= rom_value;
                    lcd_rs_q   <= 1'b0;
                    nib_q      <= rom_value[7:4];
                    state_q    <= ST_SETUP_HI;
                    cnt_q      <= CNT_W'(SETUP_CYC - 1);
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        nib_only_q <= 1'b0;
                        rs_q       <= req_rs;
                        data_q     <= req_data;
                        lcd_rs_q   <= req_rs;
                        nib_q      <= req_data[7:4];
                        state_q    <= ST_SETUP_HI;
                        cnt_q      <= CNT_W'(SETUP_CYC - 1);
                    end
                end
                ST_SETUP_HI: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b1;
                        state_q <= ST_PULSE_HI;
                        cnt_q   <= CNT_W'(PULSE_CYC - 1);
                    end
                end
                ST_PULSE_HI: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b0;
                        if (nib_only_q) begin
                            state_q <= ST_EXEC;
                            cnt_q   <= exec_load_d;
                        end else begin
                            state_q <= ST_GAP;
                            cnt_q   <= CNT_W'(GAP_CYC - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        nib_q   <= data_q[3:0];
                        state_q <= ST_SETUP_LO;
                        cnt_q   <= CNT_W'(SETUP_CYC - 1);
                    end
                end
                ST_SETUP_LO: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b1;
                        state_q <= ST_PULSE_LO;
                        cnt_q   <= CNT_W'(PULSE_CYC - 1);
                    end
                end
                ST_PULSE_LO: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b0;
                        state_q <= ST_EXEC;
                        cnt_q   <= exec_load_d;
                    end
                end
                ST_EXEC: begin
                    if (cnt_zero) begin
                        if (init_done_q) begin
                            state_q <= ST_IDLE;
                        end else if (idx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
                            init_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_INIT_STEP;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    lcd_e_q <= 1'b0;
                    state_q <= ST_PWRUP;
                    cnt_q   <= CNT_W'(PWRUP_CYC - 1);
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE) && init_done_q;
    assign busy      = !req_ready;
    assign init_done = init_done_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_4     = nib_q[0];
    assign lcd_5     = nib_q[1];
    assign lcd_6     = nib_q[2];
    assign lcd_7     = nib_q[3];

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Scoreboard bench: stimulus queues expected e-pulses, a monitor pops and compares each one.
module tb_lcd_nibble_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       init_done;
    logic       busy;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_4, lcd_5, lcd_6, lcd_7;

    always #5 clk = ~clk;

    lcd_nibble_sequencer #(
        .PWRUP_CYC     (20),
        .SETUP_CYC     (2),
        .PULSE_CYC     (3),
        .GAP_CYC       (4),
        .EXEC_CYC      (10),
        .CLEAR_CYC     (30),
        .INIT_LONG_CYC (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .init_done (init_done),
        .busy      (busy),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_4     (lcd_4),
        .lcd_5     (lcd_5),
        .lcd_6     (lcd_6),
        .lcd_7     (lcd_7)
    );

    typedef struct packed {
        logic       rs;
        logic [3:0] nib;
    } pulse_t;

    localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                              4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    // PWRUP 20 + nibble steps 21+36+16+16 + bytes 25+25+25+45
    localparam int INIT_TOTAL = 229;
    localparam int BYTE_BUSY  = 14;

    pulse_t exp_q[$];
    int     checks      = 0;
    int     failures    = 0;
    int     pulses_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin : monitor
        logic       in_pulse;
        int         width;
        logic       cap_rs;
        logic [3:0] cap_nib;
        pulse_t     exp;
        in_pulse = 1'b0;
        width    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pulse = 1'b0;
            end else if (lcd_e) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    width    = 0;
                    cap_rs   = lcd_rs;
                    cap_nib  = {lcd_7, lcd_6, lcd_5, lcd_4};
                end
                width++;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                pulses_seen++;
                check("pulse_hold", {27'd0, lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4},
                      {27'd0, cap_rs, cap_nib});
                check("pulse_rw", lcd_rw, 1'b0);
                if (exp_q.size() == 0) begin
                    check("pulse_unexpected", {27'd0, cap_rs, cap_nib}, 32'hFFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("pulse_rs", cap_rs, exp.rs);
                    check("pulse_nibble", cap_nib, exp.nib);
                    check("pulse_width", width, 3);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic push_init();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(pulse_t'({1'b0, INIT_NIBS[i]}));
        end
    endtask

    task automatic run_init();
        int n;
        rst = 1'b0;
        n   = 0;
        while (!init_done && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", n, INIT_TOTAL);
        check("init_done", init_done, 1'b1);
        check("ready_after_init", req_ready, 1'b1);
        check("busy_after_init", busy, 1'b0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) check("ready_timeout", req_ready, 1'b1);
    endtask

    task automatic offer(input logic rs, input logic [7:0] d);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        exp_q.push_back(pulse_t'({rs, d[7:4]}));
        exp_q.push_back(pulse_t'({rs, d[3:0]}));
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] d, output int busy_cyc);
        wait_ready();
        offer(rs, d);
        @(negedge clk);
        req_valid = 1'b0;
        busy_cyc  = 0;
        while (busy && busy_cyc < 2000) begin
            busy_cyc++;
            @(negedge clk);
        end
    endtask

    initial begin : stimulus
        int b;
        int n;
        int idle;
        int base;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_lcd_e", lcd_e, 1'b0);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        check("rst_nibble", {lcd_7, lcd_6, lcd_5, lcd_4}, 4'h0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy", busy, 1'b1);

        push_init();
        run_init();

        send_byte(1'b1, 8'h41, b);
        check("busy_data_0x41", b, 24);

        send_byte(1'b0, 8'h01, b);
        check("exec_clear_0x01", b - BYTE_BUSY, 30);
        send_byte(1'b0, 8'h80, b);
        check("exec_normal_0x80", b - BYTE_BUSY, 10);
        send_byte(1'b0, 8'h03, b);
        check("exec_home_0x03", b - BYTE_BUSY, 30);
        send_byte(1'b1, 8'h01, b);
        check("exec_data_0x01", b - BYTE_BUSY, 10);

        // Back-to-back: valid stays high across the first byte's EXEC.
        wait_ready();
        offer(1'b1, 8'h48);
        @(negedge clk);
        offer(1'b1, 8'h49);
        n = 0;
        while (!req_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_busy", n, 24);
        idle = 0;
        while (req_ready && idle < 10) begin
            idle++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_idle_cycles", idle, 1);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("b2b_second_busy", n, 24);

        // Reset while the low nibble of 0x55 is being pulsed.
        wait_ready();
        offer(1'b1, 8'h55);
        @(negedge clk);
        req_valid = 1'b0;
        base = pulses_seen;
        n    = 0;
        while (pulses_seen == base && n < 200) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!lcd_e && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("pulse_lo_seen", lcd_e, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lcd_e", lcd_e, 1'b0);
        check("midrst_init_done", init_done, 1'b0);
        check("midrst_ready", req_ready, 1'b0);
        check("midrst_lcd_rs", lcd_rs, 1'b0);
        check("midrst_nibble", {lcd_7, lcd_6, lcd_5, lcd_4}, 4'h0);
        exp_q.delete();
        push_init();
        repeat (2) @(negedge clk);
        run_init();

        send_byte(1'b1, 8'hA7, b);
        check("busy_after_rerun", b, 24);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
